// File: rtl/wb_arbiter2_if.sv
// wb_if: Wishbone B4 pipelined bus bundle.
//   master modport: drives cyc/stb/adr/we/sel/dat_m, receives dat_s/ack/err/stall.
//   slave  modport: the mirror image.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, adr, we, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, adr, we, sel, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone B4 pipelined arbiter.
//   Merges the instruction (m0) and data (m1) buses onto one downstream bus.
//   Registered grant, round-robin or fixed priority (m1 wins). The grant is
//   held while transfers are outstanding and dropped only when the granted
//   master releases cyc; at least one IDLE cycle separates grants.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   m0   - wb_if.slave,  master 0 (instruction)
//   m1   - wb_if.slave,  master 1 (data)
//   s    - wb_if.master, shared downstream bus
// Optional feature (macro WB_ARB_TIMEOUT_EN): watchdog that errors out the
//   granted master and drops the cycle when the slave stops responding for
//   TIMEOUT_CYCLES cycles with transfers outstanding.
module wb_arbiter2 #(
  parameter int ROUND_ROBIN     = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;   // last winner: 0 = m0, 1 = m1
  logic          full, acc, rsp, tmo;

  assign full = (cnt == CW'(MAX_OUTSTANDING));
  assign acc  = s.stb && !s.stall;
  // Responses outside a grant cannot belong to anything we track.
  assign rsp  = (state != IDLE) && (s.ack || s.err);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WW-1:0] wdog;

  // wdog counts silent cycles starting the cycle after the first accept, so
  // it fires on the TIMEOUT_CYCLES-th silent cycle.
  assign tmo = (state != IDLE) && (cnt != '0) && !rsp &&
               (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                           wdog <= '0;
    else if (state == IDLE || state_nxt != state || rsp) wdog <= '0;
    else if (cnt != '0)                                 wdog <= wdog + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state / grant
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc)
          state_nxt = (ROUND_ROBIN != 0 && last) ? GNT0 : GNT1;
        else if (m0.cyc)
          state_nxt = GNT0;
        else if (m1.cyc)
          state_nxt = GNT1;
      end
      GNT0: if (!m0.cyc || tmo) begin state_nxt = IDLE; last_nxt = 1'b0; end
      GNT1: if (!m1.cyc || tmo) begin state_nxt = IDLE; last_nxt = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  // Outstanding count: a cyc drop (or timeout) aborts everything in flight.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt == IDLE)
      cnt_nxt = '0;
    else if (acc && !rsp)
      cnt_nxt = cnt + CW'(1);
    else if (rsp && !acc && cnt != '0)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Bus forwarding. Full stall is based on the registered count, so a
  // response in a full cycle only frees a slot from the next cycle on.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.adr    = '0;
    s.we     = 1'b0;
    s.sel    = '0;
    s.dat_m  = '0;
    m0.dat_s = s.dat_s;
    m1.dat_s = s.dat_s;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.stall = 1'b1;
    case (state)
      GNT0: begin
        s.cyc    = m0.cyc && !tmo;
        s.stb    = m0.cyc && m0.stb && !full && !tmo;
        s.adr    = m0.adr;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.dat_m  = m0.dat_m;
        m0.ack   = s.ack;
        m0.err   = s.err || tmo;
        m0.stall = s.stall || full;
      end
      GNT1: begin
        s.cyc    = m1.cyc && !tmo;
        s.stb    = m1.cyc && m1.stb && !full && !tmo;
        s.adr    = m1.adr;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.dat_m  = m1.dat_m;
        m1.ack   = s.ack;
        m1.err   = s.err || tmo;
        m1.stall = s.stall || full;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_if a0();
  wb_if a1();
  wb_if as();
  wb_if b0();
  wb_if b1();
  wb_if bs();

  wb_arbiter2 #(.ROUND_ROBIN(1), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1), .s(as)
  );

  wb_arbiter2 #(.ROUND_ROBIN(0), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) u_fp (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1), .s(bs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a0.cyc = 0; a0.stb = 0; a0.adr = '0; a0.we = 0; a0.sel = '0; a0.dat_m = '0;
    a1.cyc = 0; a1.stb = 0; a1.adr = '0; a1.we = 0; a1.sel = '0; a1.dat_m = '0;
    b0.cyc = 0; b0.stb = 0; b0.adr = '0; b0.we = 0; b0.sel = '0; b0.dat_m = '0;
    b1.cyc = 0; b1.stb = 0; b1.adr = '0; b1.we = 0; b1.sel = '0; b1.dat_m = '0;
    as.dat_s = '0; as.ack = 0; as.err = 0; as.stall = 0;
    bs.dat_s = '0; bs.ack = 0; bs.err = 0; bs.stall = 0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_scyc",    as.cyc,   1'b0);
    chk("rst_m0stall", a0.stall, 1'b1);
    chk("rst_m1stall", a1.stall, 1'b1);
    chk("rst_fp_scyc", bs.cyc,   1'b0);

    // m0 single read at 0x100
    tick(); a0.cyc = 1; a0.stb = 1; a0.adr = 32'h100; a0.sel = 4'hf; #1;
    chk("rd_idle_scyc", as.cyc, 1'b0);
    tick();
    chk("rd_scyc",    as.cyc,   1'b1);
    chk("rd_sstb",    as.stb,   1'b1);
    chk("rd_sadr",    as.adr,   32'h100);
    chk("rd_m0stall", a0.stall, 1'b0);
    chk("rd_m1stall", a1.stall, 1'b1);
    tick(); a0.stb = 0; #1;
    chk("rd_wait_m1stall", a1.stall, 1'b1);
    tick(); as.ack = 1; as.dat_s = 32'hDEADBEEF; #1;
    chk("rd_m0ack",    a0.ack,   1'b1);
    chk("rd_m0dat",    a0.dat_s, 32'hDEADBEEF);
    chk("rd_m1ack",    a1.ack,   1'b0);
    chk("rd_m1stall2", a1.stall, 1'b1);
    tick(); as.ack = 0; a0.cyc = 0; #1;
    chk("rd_rel_scyc", as.cyc, 1'b0);
    tick();
    chk("rd_idle2_scyc", as.cyc, 1'b0);

    // round-robin from reset
    rst = 1; tick(); rst = 0;
    a0.cyc = 1; a1.cyc = 1; #1;
    chk("rr_idle_scyc", as.cyc, 1'b0);
    tick();
    chk("rr_g0_m0stall", a0.stall, 1'b0);
    chk("rr_g0_m1stall", a1.stall, 1'b1);
    chk("rr_g0_scyc",    as.cyc,   1'b1);
    a0.cyc = 0; #1;
    chk("rr_rel0_scyc", as.cyc, 1'b0);
    tick(); a0.cyc = 1; #1;
    chk("rr_gap_scyc",    as.cyc,   1'b0);
    chk("rr_gap_m1stall", a1.stall, 1'b1);
    tick();
    chk("rr_g1_m1stall", a1.stall, 1'b0);
    chk("rr_g1_m0stall", a0.stall, 1'b1);
    a1.cyc = 0; #1;
    tick(); a1.cyc = 1; #1;
    chk("rr_gap2_scyc", as.cyc, 1'b0);
    tick();
    chk("rr_g0b_m0stall", a0.stall, 1'b0);
    chk("rr_g0b_m1stall", a1.stall, 1'b1);
    a0.cyc = 0; a1.cyc = 0; #1;
    tick();

    // fixed priority: m1 always wins
    b0.cyc = 1; b1.cyc = 1; #1;
    tick();
    chk("fp_g1_m1stall", b1.stall, 1'b0);
    chk("fp_g1_m0stall", b0.stall, 1'b1);
    b1.cyc = 0; #1;
    tick(); b1.cyc = 1; #1;
    chk("fp_gap_scyc", bs.cyc, 1'b0);
    tick();
    chk("fp_g1b_m1stall", b1.stall, 1'b0);
    chk("fp_g1b_m0stall", b0.stall, 1'b1);
    b0.cyc = 0; b1.cyc = 0; #1;
    tick();

    // outstanding limit: m1 streams stb, slave holds acks
    a1.cyc = 1; a1.stb = 1; a1.adr = 32'h200; #1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("os_acc%0d_stall", i), a1.stall, 1'b0);
      chk($sformatf("os_acc%0d_sstb", i),  as.stb,   1'b1);
    end
    tick();
    chk("os_full_stall", a1.stall, 1'b1);
    chk("os_full_sstb",  as.stb,   1'b0);
    tick(); as.ack = 1; #1;
    chk("os_ack_m1ack",  a1.ack,   1'b1);
    chk("os_ack_stall",  a1.stall, 1'b1);
    chk("os_ack_sstb",   as.stb,   1'b0);
    tick(); as.ack = 0; #1;
    chk("os_acc5_stall", a1.stall, 1'b0);
    chk("os_acc5_sstb",  as.stb,   1'b1);
    tick();
    chk("os_full2_stall", a1.stall, 1'b1);
    a1.cyc = 0; a1.stb = 0; #1;
    tick();

    // reset with three outstanding in GNT1
    a1.cyc = 1; a1.stb = 1; #1;
    tick(); tick(); tick(); tick();
    chk("rs_cnt3_stall", a1.stall, 1'b0);
    a1.stb = 0; a1.cyc = 0; rst = 1; #1;
    tick(); rst = 0; as.ack = 1; #1;
    chk("rs_scyc",  as.cyc, 1'b0);
    chk("rs_m1ack", a1.ack, 1'b0);
    tick(); as.ack = 0; #1;

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: slave never acks
    a0.cyc = 1; a0.stb = 1; #1;
    tick();
    chk("to_acc_stall", a0.stall, 1'b0);
    tick(); a0.stb = 0; a1.cyc = 1; #1;
    repeat (14) tick();
    chk("to_pre_err", a0.err, 1'b0);
    tick();
    chk("to_err",  a0.err, 1'b1);
    chk("to_scyc", as.cyc, 1'b0);
    tick(); a0.cyc = 0; #1;
    chk("to_after_err", a0.err, 1'b0);
    chk("to_idle_scyc", as.cyc, 1'b0);
    tick();
    chk("to_g1_m1stall", a1.stall, 1'b0);
    chk("to_g1_scyc",    as.cyc,   1'b1);
    a1.cyc = 0; #1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
